fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS pipeline. Owns the program counter register.
//  It consumes the next-PC value chosen by the upstream PC-select mux.
//  It returns pc+4 to that mux as the sequential candidate.
//  It issues req/ready/valid requests to instruction memory and presents fetched words to decode.
//  Handles decode stall, branch/jump flush, and responses still in flight when a flush occurs.
// PARAMETERS
//  RESET_PC  32'h0040_0030  PC value loaded on reset
//  ADDR_W    32             PC / address width
//  DATA_W    32             instruction width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  next_pc_in  in   ADDR_W  PC chosen by the PC-select mux; loaded when PC advances or on flush
//  stall       in   1       decode cannot accept a new instruction this cycle
//  flush       in   1       redirect: discard in-flight/held fetch, load next_pc_in
//  pc_out      out  ADDR_W  current PC register
//  pc_plus4    out  ADDR_W  pc_out + 4, modulo 2^ADDR_W, combinational
//  imem_req    out  1       fetch request valid
//  imem_addr   out  ADDR_W  fetch address; equals pc_out
//  imem_ready  in   1       memory accepts the request this cycle
//  imem_valid  in   1       response data valid; at most one outstanding
//  imem_rdata  in   DATA_W  instruction word
//  if_valid    out  1       if_instr/if_pc hold a valid instruction for decode
//  if_instr    out  DATA_W  fetched instruction, registered
//  if_pc       out  ADDR_W  PC of if_instr, registered
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, hold buffer cleared.
//  Reset outputs: imem_req=0, pc_plus4=RESET_PC+4.
//  FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. imem_req=1 only in REQ.
//  - IDLE: goes to REQ unconditionally on the next edge. Provides one bubble cycle after reset.
//  - REQ: on imem_ready, go to WAIT; else stay in REQ. imem_addr is held stable until ready.
//  - WAIT: on imem_valid with stall=0, do all of the following on that edge, then go to REQ:
//      if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=next_pc_in.
//  - WAIT: on imem_valid with stall=1, capture {imem_rdata, pc} in the hold buffer and go to HOLD.
//      The PC is not advanced.
//  - HOLD: when stall=0, move the hold buffer to the if_* registers, set if_valid<=1,
//      load pc<=next_pc_in, and go to REQ.
//  - DRAIN: a discarded request is still outstanding. On imem_valid, drop the data and go to REQ.
//  if_valid clears when stall=0 and no new word is loaded in that cycle (decode consumed it).
//  While stall=1, if_valid/if_instr/if_pc are held unchanged.
//  Best case: one instruction every 2 cycles (REQ+WAIT) with single-cycle memory.
//  Flush is synchronous and has priority over every rule except reset. On flush:
//    if_valid<=0, hold buffer discarded, pc<=next_pc_in.
//    Next state on flush:
//      REQ, imem_ready=0: REQ. The request is withdrawn; memory latches only on ready.
//      REQ, imem_ready=1: DRAIN.
//      WAIT, imem_valid=0: DRAIN.
//      WAIT, imem_valid=1: REQ; response dropped.
//      HOLD, IDLE, or DRAIN with imem_valid=1: REQ.
//      DRAIN with imem_valid=0: stays in DRAIN.
//  Flush and stall asserted together: flush wins; the if_* contents become invalid.
//  imem_valid outside WAIT/DRAIN: ignored. Must not occur; the bench asserts this.
//  PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no trap.
//  No alignment check is made on next_pc_in.
// TESTING
//  1 Reset, then release; memory ready=1, valid the cycle after acceptance.
//    -> imem_addr=0x00400030, then 0x00400034.
//    -> if_pc=0x00400030 with if_valid=1 on the 3rd edge after release.
//  2 Hold stall=1 for 3 cycles while WAIT receives 0x2408000A.
//    -> HOLD entered; pc unchanged.
//    -> if_instr=0x2408000A appears one edge after stall drops; pc advances once.
//  3 Flush with next_pc_in=0x00400100 in WAIT before the response arrives.
//    -> DRAIN; the late word is discarded; next imem_addr=0x00400100; if_valid stays 0.
//  4 Flush in the same cycle as imem_ready in REQ.
//    -> DRAIN; one response is dropped; the next request is to the new PC.
//  5 Assert reset asynchronously mid-WAIT.
//    -> pc=0x00400030, if_valid=0, imem_req=0 immediately, without a clock edge.
//  6 pc=0xFFFFFFFC -> pc_plus4=0x00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// The instruction-fetch stage of the MIPS pipeline. It owns the program
// counter. It issues one request at a time to instruction memory over a
// req/ready + valid handshake. Each fetched word is registered for decode,
// together with the PC it came from.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   next_pc_in  PC chosen by the upstream PC-select mux. It is loaded when the
//               PC advances or on a flush.
//   stall       decode cannot accept a new instruction this cycle
//   flush       redirect: drop the in-flight or held fetch and load next_pc_in
//   pc_out      current PC register
//   pc_plus4    pc_out + 4 (wraps modulo 2^ADDR_W). This is the sequential
//               candidate returned to the PC-select mux.
//   imem_req    fetch request valid
//   imem_addr   fetch address (always pc_out)
//   imem_ready  memory accepts the request this cycle
//   imem_valid  response data valid. At most one response is outstanding.
//   imem_rdata  instruction word returned by memory
//   if_valid    if_instr / if_pc hold a valid instruction for decode
//   if_instr    fetched instruction (registered)
//   if_pc       PC of if_instr (registered)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0030
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] next_pc_in,
  input  logic              stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  // Fetch sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;  // one bubble cycle after reset
  localparam logic [2:0] ST_REQ   = 3'd1;  // request presented, waiting for ready
  localparam logic [2:0] ST_WAIT  = 3'd2;  // request accepted, waiting for data
  localparam logic [2:0] ST_HOLD  = 3'd3;  // word received while decode stalled
  localparam logic [2:0] ST_DRAIN = 3'd4;  // stale request outstanding after flush

  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic              if_valid_q,   if_valid_d;
  logic [DATA_W-1:0] if_instr_q,   if_instr_d;
  logic [ADDR_W-1:0] if_pc_q,      if_pc_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q,    hold_pc_d;

  // Sources for a word delivered to decode this cycle
  logic              load_mem;     // straight from the memory response
  logic              load_hold;    // from the hold buffer
  logic              load_any;

  // -------------------------------------------------------------------------
  // Normal (non-flush) sequencing
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load_mem     = 1'b0;
    load_hold    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          if (!stall) begin
            load_mem = 1'b1;
            state_d  = ST_REQ;
          end else begin
            // Decode is busy. Park the word and keep the PC where it is.
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          load_hold = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // The response belongs to a redirected fetch. Drop it.
        if (imem_valid) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush overrides the normal next state. The target depends on whether
    // a request is still owed a response from memory.
    if (flush) begin
      hold_instr_d = '0;
      hold_pc_d    = '0;
      case (state_q)
        ST_REQ:   state_d = imem_ready ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_valid ? ST_REQ   : ST_DRAIN;
        ST_DRAIN: state_d = imem_valid ? ST_REQ   : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  assign load_any = (load_mem | load_hold) & ~flush;

  // -------------------------------------------------------------------------
  // PC and decode-facing registers
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (flush) begin
      // Redirect. Whatever decode was holding is no longer on the path.
      if_valid_d = 1'b0;
      pc_d       = next_pc_in;
    end else if (load_any) begin
      if_valid_d = 1'b1;
      if_instr_d = load_hold ? hold_instr_q : imem_rdata;
      if_pc_d    = load_hold ? hold_pc_q    : pc_q;
      pc_d       = next_pc_in;
    end else if (!stall) begin
      // Decode consumed the word and nothing replaced it.
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc_out    = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);   // wraps naturally at the top of memory
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;                // stays stable while REQ waits for ready
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule
